// File: rtl/gpout_pkg.sv
// rtl/gpout_pkg.sv - op codes and pulse FSM state encoding for gpout_ctrl
package gpout_pkg;

  localparam logic [2:0] GP_OP_LOAD   = 3'd0;
  localparam logic [2:0] GP_OP_SET    = 3'd1;
  localparam logic [2:0] GP_OP_CLR    = 3'd2;
  localparam logic [2:0] GP_OP_TOGGLE = 3'd3;
  localparam logic [2:0] GP_OP_PULSE  = 3'd4;

  typedef enum logic [0:0] {
    GP_ST_IDLE  = 1'b0,
    GP_ST_PULSE = 1'b1
  } gp_state_e;

endpackage

// File: rtl/gpout_pulse_timer.sv
// rtl/gpout_pulse_timer.sv - pulse FSM and down-counter; expire marks the final pulse cycle
module gpout_pulse_timer
  import gpout_pkg::*;
#(
  parameter int PW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [PW-1:0] len,
  output logic          busy,
  output logic          expire
);

  gp_state_e     state_q, state_d;
  logic [PW-1:0] cnt_q, cnt_d;

  // State and counter registers; reset abandons any pulse in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= GP_ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: load len-1 on start (caller guarantees len != 0), count down to zero, then idle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      GP_ST_IDLE: begin
        if (start) begin
          state_d = GP_ST_PULSE;
          cnt_d   = len - PW'(1);
        end
      end
      GP_ST_PULSE: begin
        if (cnt_q == '0) begin
          state_d = GP_ST_IDLE;
        end else begin
          cnt_d = cnt_q - PW'(1);
        end
      end
      default: state_d = GP_ST_IDLE;
    endcase
  end

  // Outputs depend on state only: busy for the whole pulse, expire on its last cycle
  always_comb begin
    busy   = (state_q == GP_ST_PULSE);
    expire = (state_q == GP_ST_PULSE) && (cnt_q == '0);
  end

endmodule

// File: rtl/gpout_ctrl.sv
// rtl/gpout_ctrl.sv - registered masked output bits; timed pulses built only with GPOUT_PULSE_EN
module gpout_ctrl
  import gpout_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               PW        = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_mask,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [PW-1:0]    cmd_len,
  output logic [WIDTH-1:0] gpout,
  output logic             busy,
  output logic             done
);

  logic [WIDTH-1:0] gpout_q, gpout_d;
  logic             accept;

`ifdef GPOUT_PULSE_EN
  logic [WIDTH-1:0] pulse_mask_q, pulse_mask_d;
  logic             done_q, done_d;
  logic             pulse_cmd, pulse_start, pulse_nop;
  logic             tmr_busy, tmr_expire;

  gpout_pulse_timer #(.PW(PW)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (pulse_start),
    .len    (cmd_len),
    .busy   (tmr_busy),
    .expire (tmr_expire)
  );

  // A pulse only runs when it would actually change something; otherwise it just reports done
  always_comb begin
    pulse_cmd   = accept && (cmd_op == GP_OP_PULSE);
    pulse_start = pulse_cmd && (cmd_len != '0) && (cmd_mask != '0);
    pulse_nop   = pulse_cmd && !pulse_start;
    pulse_mask_d = pulse_start ? cmd_mask : pulse_mask_q;
    done_d       = tmr_expire || pulse_nop;
  end

  // Pulse mask and done strobe registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse_mask_q <= '0;
      done_q       <= 1'b0;
    end else begin
      pulse_mask_q <= pulse_mask_d;
      done_q       <= done_d;
    end
  end

  assign cmd_ready = !tmr_busy;
  assign busy      = tmr_busy;
  assign done      = done_q;
`else
  logic unused_len;
  assign unused_len = ^cmd_len;
  assign cmd_ready  = 1'b1;
  assign busy       = 1'b0;
  assign done       = 1'b0;
`endif

  assign accept = cmd_valid && cmd_ready;

  // Op decode; pulse revert cannot collide with a command because ready is low while busy
  always_comb begin
    gpout_d = gpout_q;
    if (accept) begin
      case (cmd_op)
        GP_OP_LOAD:   gpout_d = (gpout_q & ~cmd_mask) | (cmd_data & cmd_mask);
        GP_OP_SET:    gpout_d = gpout_q | cmd_mask;
        GP_OP_CLR:    gpout_d = gpout_q & ~cmd_mask;
        GP_OP_TOGGLE: gpout_d = gpout_q ^ cmd_mask;
`ifdef GPOUT_PULSE_EN
        GP_OP_PULSE:  if (pulse_start) gpout_d = gpout_q ^ cmd_mask;
`endif
        default:      gpout_d = gpout_q;
      endcase
    end
`ifdef GPOUT_PULSE_EN
    if (tmr_expire) gpout_d = gpout_q ^ pulse_mask_q;
`endif
  end

  // Output bit register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gpout_q <= RESET_VAL;
    end else begin
      gpout_q <= gpout_d;
    end
  end

  assign gpout = gpout_q;

endmodule

// File: tb/tb_gpout_ctrl.sv
// tb/tb_gpout_ctrl.sv - directed self-checking bench for gpout_ctrl (both GPOUT_PULSE_EN builds)
module tb_gpout_ctrl;

  localparam logic [31:0] RV = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [31:0] cmd_mask;
  logic [31:0] cmd_data;
  logic [15:0] cmd_len;
  logic [31:0] gpout;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  gpout_ctrl #(.WIDTH(32), .PW(16), .RESET_VAL(RV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_mask  (cmd_mask),
    .cmd_data  (cmd_data),
    .cmd_len   (cmd_len),
    .gpout     (gpout),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic flags(input string tag, input logic rdy, input logic bsy, input logic dn);
    chk({tag, "_ready"}, {31'd0, cmd_ready}, {31'd0, rdy});
    chk({tag, "_busy"},  {31'd0, busy},      {31'd0, bsy});
    chk({tag, "_done"},  {31'd0, done},      {31'd0, dn});
  endtask

  // Drive at negedge, accept on the following posedge, return at the next negedge
  task automatic cmd(input logic [2:0] op, input logic [31:0] mask, input logic [31:0] data,
                     input logic [15:0] len);
    cmd_op    = op;
    cmd_mask  = mask;
    cmd_data  = data;
    cmd_len   = len;
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_mask  = '0;
    cmd_data  = '0;
    cmd_len   = '0;
    repeat (2) @(negedge clk);
    chk("rst_gpout", gpout, RV);
    flags("rst", 1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_gpout", gpout, RV);

    // Basic ops from zero
    cmd(3'd0, 32'hFFFF_FFFF, 32'h0000_0000, 16'd0);
    chk("load_zero", gpout, 32'h0000_0000);
    cmd(3'd0, 32'h0000_FFFF, 32'h1234_5678, 16'd0);
    chk("load", gpout, 32'h0000_5678);
    cmd(3'd1, 32'hF000_0000, 32'h0, 16'd0);
    chk("set", gpout, 32'hF000_5678);
    cmd(3'd2, 32'h0000_0078, 32'h0, 16'd0);
    chk("clr", gpout, 32'hF000_5600);
    cmd(3'd3, 32'h0000_0101, 32'h0, 16'd0);
    chk("toggle", gpout, 32'hF000_5701);
    cmd(3'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'd3);
    chk("op6", gpout, 32'hF000_5701);
    cmd(3'd0, 32'hFFFF_FFFF, 32'h0000_0000, 16'd0);
    chk("load_zero2", gpout, 32'h0000_0000);

`ifdef GPOUT_PULSE_EN
    // PULSE len 5 on bit0, with a SET held valid throughout
    cmd_op = 3'd4; cmd_mask = 32'h1; cmd_len = 16'd5; cmd_data = '0;
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_op = 3'd1; cmd_mask = 32'h0000_0100;
    for (int k = 1; k <= 5; k++) begin
      chk($sformatf("pulse_c%0d_gpout", k), gpout, 32'h1);
      flags($sformatf("pulse_c%0d", k), 1'b0, 1'b1, 1'b0);
      @(negedge clk);
    end
    chk("pulse_end_gpout", gpout, 32'h0);
    flags("pulse_end", 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("held_set_gpout", gpout, 32'h0000_0100);
    flags("held_set", 1'b1, 1'b0, 1'b0);

    // Degenerate pulses: no change, done next cycle, never busy
    cmd(3'd4, 32'h0000_00FF, 32'h0, 16'd0);
    chk("len0_gpout", gpout, 32'h0000_0100);
    flags("len0", 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    flags("len0_after", 1'b1, 1'b0, 1'b0);
    cmd(3'd4, 32'h0, 32'h0, 16'd7);
    chk("mask0_gpout", gpout, 32'h0000_0100);
    flags("mask0", 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    flags("mask0_after", 1'b1, 1'b0, 1'b0);

    // Reset three cycles into a long pulse
    cmd(3'd4, 32'h0000_00F0, 32'h0, 16'd100);
    chk("long_c1_gpout", gpout, 32'h0000_01F0);
    repeat (2) @(negedge clk);
    chk("long_c3_gpout", gpout, 32'h0000_01F0);
    flags("long_c3", 1'b0, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_gpout", gpout, RV);
    flags("midrst", 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      flags($sformatf("after_rst%0d", k), 1'b1, 1'b0, 1'b0);
    end
    cmd(3'd1, 32'h1, 32'h0, 16'd0);
    chk("after_rst_set", gpout, RV | 32'h1);
    flags("after_rst_set", 1'b1, 1'b0, 1'b0);
`else
    // PULSE op is reserved in this build
    cmd(3'd4, 32'h0000_00FF, 32'h0, 16'd10);
    chk("nopulse_gpout", gpout, 32'h0);
    for (int k = 0; k < 12; k++) begin
      flags($sformatf("nopulse_c%0d", k), 1'b1, 1'b0, 1'b0);
      chk($sformatf("nopulse_c%0d_gpout", k), gpout, 32'h0);
      @(negedge clk);
    end
    cmd(3'd1, 32'h0000_0003, 32'h0, 16'd0);
    chk("nopulse_set", gpout, 32'h0000_0003);
    rst_n = 1'b0;
    #1;
    chk("midrst_gpout", gpout, RV);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cmd(3'd3, 32'h8000_0001, 32'h0, 16'd0);
    chk("after_rst_toggle", gpout, 32'h25A5_0001);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gpout_ctrl.md
# gpout_ctrl

Parametrised general-purpose output controller: the registered, command-driven successor to the flat 32-bit output breakout. It holds `WIDTH` output bits in flops, updates them by masked load/set/clear/toggle commands over a valid/ready handshake, and optionally generates timed single-shot pulses on selected bits. It sits between the processor-side register interface and the motion-board output pins (enables, direction, strobes).

## Interface
- `WIDTH`, 32: number of output bits.
- `PW`, 16: pulse length counter width.
- `RESET_VAL`, 0: value of `gpout` after reset (`WIDTH` bits).

- `clk`  in  1  system clock, all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command.
- `cmd_op`  in  3  operation code (see Operation).
- `cmd_mask`  in  WIDTH  bits affected by the command.
- `cmd_data`  in  WIDTH  data for LOAD.
- `cmd_len`  in  PW  pulse length in cycles for PULSE.
- `gpout`  out  WIDTH  registered output bits.
- `busy`  out  1  pulse in progress.
- `done`  out  1  one-cycle strobe at pulse completion.

## Operation
- Command accepted on a rising edge with `cmd_valid && cmd_ready`; unaccepted commands have no effect.
- Ops: 0 LOAD `gpout <= (gpout & ~mask) | (data & mask)`; 1 SET `gpout <= gpout | mask`; 2 CLR `gpout <= gpout & ~mask`; 3 TOGGLE `gpout <= gpout ^ mask`; 4 PULSE; 5–7 reserved, accepted, no effect.
- PULSE: masked bits invert on accept, stay inverted exactly `cmd_len` cycles, then revert (XOR with latched `pulse_mask`).
- FSM: IDLE, PULSE. IDLE→PULSE on accepted PULSE with `cmd_len != 0` and `cmd_mask != 0`; load `cnt <= cmd_len - 1`, latch mask. In PULSE: if `cnt == 0`, revert bits, assert `done`, go IDLE; else `cnt <= cnt - 1`.
- PULSE with `cmd_len == 0` or `cmd_mask == 0`: no output change, stays IDLE, `done` asserted the following cycle.
- `cmd_ready` = 1 in IDLE, 0 in PULSE. No commands are accepted during a pulse.
- `busy` = 1 exactly while the state is PULSE.
- Reset (any time, including mid-pulse): `gpout = RESET_VAL`, state IDLE, `cnt = 0`, `pulse_mask = 0`, `busy = 0`, `done = 0`, `cmd_ready = 1` after deassertion. An interrupted pulse is not resumed.

## Timing
- LOAD/SET/CLR/TOGGLE: `gpout` changes at the accept edge and is visible the cycle after. Latency is 1.
- PULSE len N≥1: accept at edge t0. Bits inverted during cycles t0+1 … t0+N. Revert at edge t0+N, visible from t0+N+1.
- `done` is high exactly in cycle t0+N+1. `cmd_ready` returns high in that same cycle, so back-to-back pulses are possible.
- Maximum pulse: 2^PW − 1 cycles. No wrap-around, because `cnt` never decrements below 0.
- `cmd_ready` depends only on state, not on `cmd_valid`. There is no combinational path from inputs to outputs.

## Configuration
- `GPOUT_PULSE_EN` defined: PULSE op, FSM, counter, `busy` and `done` are built as described.
- Not defined: op 4 is treated as reserved (no effect). `cmd_len` is ignored. `busy` and `done` are tied 0 and `cmd_ready` is tied 1. No counter flops are built.

## Structure
- Package `gpout_pkg` holds:
  - op code constants `GP_OP_LOAD`, `GP_OP_SET`, `GP_OP_CLR`, `GP_OP_TOGGLE`, `GP_OP_PULSE`;
  - the state encoding `GP_ST_IDLE`, `GP_ST_PULSE`.
- Sub-module `gpout_pulse_timer` (parameter `PW`) contains the FSM and down-counter, with ports `start`, `len`, `busy`, `expire`. Instantiate it only under `GPOUT_PULSE_EN`.
- The top level holds the `gpout` register, op decode and `pulse_mask`.

## Test plan
- Reset with `RESET_VAL=32'hA5A5_0000` → `gpout=32'hA5A5_0000`, `cmd_ready=1`, `busy=0`, `done=0`.
- From 0: LOAD mask `32'h0000_FFFF` data `32'h1234_5678` → `gpout=32'h0000_5678`; then SET `32'hF000_0000` → `32'hF000_5678`; CLR `32'h0000_0078` → `32'hF000_5600`; TOGGLE `32'h0000_0101` → `32'hF000_5701`. Each change visible 1 cycle after accept.
- PULSE mask `32'h1` len 5 on `gpout=0` → bit0 high for exactly 5 cycles, `busy` high for those 5 cycles, `cmd_ready=0` throughout. Then `done` for 1 cycle; a `cmd_valid` held during the pulse is accepted only in the `done` cycle.
- PULSE len 0, and PULSE mask 0 → `gpout` unchanged, `busy` never high, `done` one cycle later; op 6 → no change.
- Reset asserted 3 cycles into a PULSE len 100 → `gpout=RESET_VAL` immediately, `busy=0`, no `done`, normal commands accepted after release.
- Build without `GPOUT_PULSE_EN`: PULSE mask `32'hFF` len 10 → `gpout` unchanged, `cmd_ready` stays 1, `busy`/`done` stay 0.
